// File: rtl/iomem_arbiter_pkg.sv
// Shared types and default widths for the iomem two-master arbiter.
package iomem_arb_pkg;

  localparam int BLOCK_SIZE_DEF = 128;
  localparam int NUMS_BYTE_DEF  = BLOCK_SIZE_DEF / 8;
  localparam int ADDR_W_DEF     = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  typedef logic grant_t;

  localparam grant_t GRANT_M0 = 1'b0;
  localparam grant_t GRANT_M1 = 1'b1;

endpackage

// File: rtl/iomem_arbiter_if.sv
// Bundle of both master ports and the shared iomem port; the arbiter takes the slave view.
interface iomem_arb_if
  import iomem_arb_pkg::*;
#(
  parameter int BLOCK_SIZE = BLOCK_SIZE_DEF,
  parameter int NUMS_BYTE  = BLOCK_SIZE / 8,
  parameter int ADDR_W     = ADDR_W_DEF
);

  logic                  m0_valid;
  logic                  m0_ready;
  logic [ADDR_W-1:0]     m0_addr;
  logic [BLOCK_SIZE-1:0] m0_rdata;

  logic                  m1_valid;
  logic                  m1_ready;
  logic [NUMS_BYTE-1:0]  m1_wstrb;
  logic [ADDR_W-1:0]     m1_addr;
  logic [BLOCK_SIZE-1:0] m1_wdata;
  logic [BLOCK_SIZE-1:0] m1_rdata;

  logic                  mem_valid;
  logic                  mem_ready;
  logic [NUMS_BYTE-1:0]  mem_wstrb;
  logic [ADDR_W-1:0]     mem_addr;
  logic [BLOCK_SIZE-1:0] mem_wdata;
  logic [BLOCK_SIZE-1:0] mem_rdata;

  modport slave (
    input  m0_valid, m0_addr,
    input  m1_valid, m1_wstrb, m1_addr, m1_wdata,
    input  mem_ready, mem_rdata,
    output m0_ready, m0_rdata,
    output m1_ready, m1_rdata,
    output mem_valid, mem_wstrb, mem_addr, mem_wdata
  );

  modport master (
    output m0_valid, m0_addr,
    output m1_valid, m1_wstrb, m1_addr, m1_wdata,
    output mem_ready, mem_rdata,
    input  m0_ready, m0_rdata,
    input  m1_ready, m1_rdata,
    input  mem_valid, mem_wstrb, mem_addr, mem_wdata
  );

endinterface

// File: rtl/iomem_arbiter_pick.sv
// Combinational winner select between m0/m1. IOMEM_ARB_RR_EN selects round-robin ties,
// otherwise m1 has fixed priority on ties.
module iomem_arb_pick
  import iomem_arb_pkg::*;
(
  input  logic   i_m0_valid,
  input  logic   i_m1_valid,
  input  grant_t i_last_grant,
  output grant_t o_grant
);

`ifdef IOMEM_ARB_RR_EN
  always_comb begin
    o_grant = GRANT_M0;
    if (i_m1_valid && !i_m0_valid) begin
      o_grant = GRANT_M1;
    end else if (i_m1_valid && i_m0_valid) begin
      o_grant = ~i_last_grant;
    end
  end
`else
  // History is kept by the top even in fixed mode; it simply has no effect here.
  grant_t w_unused_last_grant;
  assign w_unused_last_grant = i_last_grant;

  always_comb begin
    o_grant = GRANT_M0;
    if (i_m1_valid) begin
      o_grant = GRANT_M1;
    end
  end
`endif

endmodule

// File: rtl/iomem_arbiter.sv
// Shares the 128-bit iomem port between instruction refill (m0) and data (m1) masters.
// One request in flight: IDLE arbitrates, BUSY holds mem_*, DONE pulses the winner's ready.
// Tie-break policy set by IOMEM_ARB_RR_EN (see iomem_arb_pick).
module iomem_arbiter
  import iomem_arb_pkg::*;
#(
  parameter int BLOCK_SIZE = BLOCK_SIZE_DEF,
  parameter int NUMS_BYTE  = BLOCK_SIZE / 8,
  parameter int ADDR_W     = ADDR_W_DEF
)(
  input  logic       clk_o,
  input  logic       rst_n,
  iomem_arb_if.slave bus
);

  arb_state_e            r_state;
  arb_state_e            w_state_nxt;
  logic                  w_load;
  logic                  w_fin;
  grant_t                w_pick;

  grant_t                r_grant;
  grant_t                r_last_grant;
  logic                  r_mem_valid;
  logic [NUMS_BYTE-1:0]  r_mem_wstrb;
  logic [ADDR_W-1:0]     r_mem_addr;
  logic [BLOCK_SIZE-1:0] r_mem_wdata;
  logic [BLOCK_SIZE-1:0] r_rdata_q;
  logic                  r_m0_ready;
  logic                  r_m1_ready;

  iomem_arb_pick u_pick (
    .i_m0_valid   (bus.m0_valid),
    .i_m1_valid   (bus.m1_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_pick)
  );

  always_ff @(posedge clk_o) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_fin       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.m0_valid || bus.m1_valid) begin
          w_load      = 1'b1;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (bus.mem_ready) begin
          w_fin       = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Payload stays latched after completion; only mem_valid is withdrawn.
  always_ff @(posedge clk_o) begin
    if (!rst_n) begin
      r_grant      <= GRANT_M0;
      r_last_grant <= GRANT_M1;
      r_mem_valid  <= 1'b0;
      r_mem_wstrb  <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_rdata_q    <= '0;
      r_m0_ready   <= 1'b0;
      r_m1_ready   <= 1'b0;
    end else begin
      r_m0_ready <= 1'b0;
      r_m1_ready <= 1'b0;
      if (w_load) begin
        r_mem_valid  <= 1'b1;
        r_grant      <= w_pick;
        r_last_grant <= w_pick;
        if (w_pick == GRANT_M1) begin
          r_mem_addr  <= bus.m1_addr;
          r_mem_wdata <= bus.m1_wdata;
          r_mem_wstrb <= bus.m1_wstrb;
        end else begin
          r_mem_addr  <= bus.m0_addr;
          r_mem_wdata <= '0;
          r_mem_wstrb <= '0;
        end
      end
      if (w_fin) begin
        r_mem_valid <= 1'b0;
        r_rdata_q   <= bus.mem_rdata;
        r_m0_ready  <= (r_grant == GRANT_M0);
        r_m1_ready  <= (r_grant == GRANT_M1);
      end
    end
  end

  assign bus.mem_valid = r_mem_valid;
  assign bus.mem_wstrb = r_mem_wstrb;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.m0_ready  = r_m0_ready;
  assign bus.m1_ready  = r_m1_ready;
  assign bus.m0_rdata  = r_rdata_q;
  assign bus.m1_rdata  = r_rdata_q;

endmodule

// File: tb/tb_iomem_arbiter.sv
// Directed bench for iomem_arbiter; expected grant order follows IOMEM_ARB_RR_EN.
module tb_iomem_arbiter;
  import iomem_arb_pkg::*;

  localparam logic [127:0] RD0 = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
  localparam logic [127:0] RD2 = 128'h1357_9BDF_2468_ACE0_FEDC_BA98_7654_3210;
  localparam logic [127:0] WD1 = 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100;
  localparam logic [31:0]  A0  = 32'h8000_0100;
  localparam logic [31:0]  A1  = 32'h8000_0200;

  logic clk_o = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clk_o = ~clk_o;

  iomem_arb_if bus ();

  iomem_arbiter dut (
    .clk_o (clk_o),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_o);
    #1;
  endtask

  initial begin
    logic   m1_seen;
    int     m0_pulses;
    logic   exp_g;
    logic [127:0] rd;

    bus.m0_valid  = 1'b0;
    bus.m0_addr   = '0;
    bus.m1_valid  = 1'b0;
    bus.m1_wstrb  = '0;
    bus.m1_addr   = '0;
    bus.m1_wdata  = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;

    tick();
    tick();
    chk("rst_mem_valid", bus.mem_valid, 0);
    chk("rst_mem_wstrb", bus.mem_wstrb, 0);
    chk("rst_mem_addr",  bus.mem_addr,  0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_m0_ready",  bus.m0_ready,  0);
    chk("rst_m1_ready",  bus.m1_ready,  0);
    chk("rst_rdata_q",   bus.m0_rdata,  0);
    rst_n = 1'b1;
    tick();

    // m0 read, slow memory
    bus.m0_valid = 1'b1;
    bus.m0_addr  = 32'h8000_0010;
    tick();
    chk("t1_mem_valid", bus.mem_valid, 1);
    chk("t1_mem_addr",  bus.mem_addr,  128'h8000_0010);
    chk("t1_mem_wstrb", bus.mem_wstrb, 0);
    m1_seen   = 1'b0;
    m0_pulses = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.m1_ready) m1_seen = 1'b1;
      if (bus.m0_ready) m0_pulses++;
    end
    chk("t1_mem_valid_held", bus.mem_valid, 1);
    chk("t1_early_ready", m0_pulses, 0);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = RD0;
    tick();
    chk("t1_m0_ready", bus.m0_ready, 1);
    chk("t1_m0_rdata", bus.m0_rdata, RD0);
    chk("t1_mem_valid_drop", bus.mem_valid, 0);
    if (bus.m1_ready) m1_seen = 1'b1;
    bus.mem_ready = 1'b0;
    bus.m0_valid  = 1'b0;
    tick();
    chk("t1_m0_ready_once", bus.m0_ready, 0);
    if (bus.m1_ready) m1_seen = 1'b1;
    chk("t1_m1_never", m1_seen, 0);

    // m1 write
    bus.m1_valid = 1'b1;
    bus.m1_wstrb = 16'h000F;
    bus.m1_addr  = 32'h8000_0020;
    bus.m1_wdata = WD1;
    tick();
    chk("t2_mem_valid", bus.mem_valid, 1);
    chk("t2_mem_wstrb", bus.mem_wstrb, 128'h000F);
    chk("t2_mem_wdata", bus.mem_wdata, WD1);
    chk("t2_mem_addr",  bus.mem_addr,  128'h8000_0020);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 128'h5;
    tick();
    chk("t2_m1_ready", bus.m1_ready, 1);
    chk("t2_m0_ready", bus.m0_ready, 0);
    chk("t2_mem_valid_drop", bus.mem_valid, 0);
    bus.mem_ready = 1'b0;
    bus.m1_valid  = 1'b0;
    bus.m1_wstrb  = '0;
    tick();
    chk("t2_m1_ready_once", bus.m1_ready, 0);

    // contention with mem_ready held high: 3-cycle back-to-back transactions
    bus.m0_valid  = 1'b1;
    bus.m0_addr   = A0;
    bus.m1_valid  = 1'b1;
    bus.m1_addr   = A1;
    bus.m1_wdata  = '0;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
`ifdef IOMEM_ARB_RR_EN
      exp_g = (i % 2 == 1);
`else
      exp_g = 1'b1;
`endif
      rd = 128'hA5A5_0000 + 128'(i);
      bus.mem_rdata = rd;
      tick();
      chk("t3_mem_valid", bus.mem_valid, 1);
      chk("t3_grant_addr", bus.mem_addr, exp_g ? A1 : A0);
      tick();
      chk("t3_mem_valid_drop", bus.mem_valid, 0);
      chk("t3_m0_ready", bus.m0_ready, !exp_g);
      chk("t3_m1_ready", bus.m1_ready, exp_g);
      chk("t3_rdata", exp_g ? bus.m1_rdata : bus.m0_rdata, rd);
      tick();
      chk("t3_no_dup_valid", bus.mem_valid, 0);
      chk("t3_ready_clear", {bus.m0_ready, bus.m1_ready}, 0);
    end
    bus.m0_valid = 1'b0;
    bus.m1_valid = 1'b0;

    // mem_ready in IDLE ignored
    tick();
    chk("idle_ready_ign_valid", bus.mem_valid, 0);
    chk("idle_ready_ign_rdy", {bus.m0_ready, bus.m1_ready}, 0);
    bus.mem_ready = 1'b0;

    // reset during BUSY
    bus.m0_valid = 1'b1;
    bus.m0_addr  = 32'h8000_0300;
    tick();
    chk("t5_busy_valid", bus.mem_valid, 1);
    tick();
    rst_n         = 1'b0;
    bus.m0_valid  = 1'b0;
    bus.mem_ready = 1'b1;
    tick();
    chk("t5_rst_mem_valid", bus.mem_valid, 0);
    chk("t5_rst_readies", {bus.m0_ready, bus.m1_ready}, 0);
    chk("t5_rst_mem_addr", bus.mem_addr, 0);
    tick();
    bus.mem_ready = 1'b0;
    rst_n         = 1'b1;
    tick();
    chk("t5_post_valid", bus.mem_valid, 0);
    chk("t5_post_readies", {bus.m0_ready, bus.m1_ready}, 0);

    // fresh m0 after reset; valid dropped mid-transaction still completes
    bus.m0_valid = 1'b1;
    bus.m0_addr  = 32'h8000_0040;
    tick();
    chk("t6_mem_valid", bus.mem_valid, 1);
    chk("t6_mem_addr", bus.mem_addr, 128'h8000_0040);
    bus.m0_valid = 1'b0;
    tick();
    chk("t6_valid_held", bus.mem_valid, 1);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = RD2;
    tick();
    chk("t6_m0_ready", bus.m0_ready, 1);
    chk("t6_m0_rdata", bus.m0_rdata, RD2);
    bus.mem_ready = 1'b0;
    tick();
    chk("t6_m0_ready_once", bus.m0_ready, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/iomem_arbiter.md
# iomem_arbiter

Two-master arbiter that shares the single 128-bit `iomem` port (main RAM plus timer MMIO) between the instruction-refill master (m0) and the data master (m1). The arbiter sits between the core's cache/LSU side and the wrapper-level memory decode. It accepts one request at a time and registers the winning request onto the memory side. It holds that request until `mem_ready`, registers the read data, and returns a one-cycle ready pulse to the winner.

## Interface
Parameters:
- `BLOCK_SIZE`, 128, data width of all data buses in bits.
- `NUMS_BYTE`, `BLOCK_SIZE/8`, strobe width.
- `ADDR_W`, 32, address width.

Ports:
- `clk_o` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `m0_valid` in 1: instruction master request.
- `m0_ready` out 1: completion pulse to m0.
- `m0_addr` in `ADDR_W`: m0 address.
- `m0_rdata` out `BLOCK_SIZE`: m0 read data.
- `m1_valid` in 1: data master request.
- `m1_ready` out 1: completion pulse to m1.
- `m1_wstrb` in `NUMS_BYTE`: m1 write strobes; all zero means read.
- `m1_addr` in `ADDR_W`: m1 address.
- `m1_wdata` in `BLOCK_SIZE`: m1 write data.
- `m1_rdata` out `BLOCK_SIZE`: m1 read data.
- `mem_valid` out 1: downstream request, registered.
- `mem_ready` in 1: downstream completion.
- `mem_wstrb` out `NUMS_BYTE`: registered strobes; always zero for m0.
- `mem_addr` out `ADDR_W`: registered address.
- `mem_wdata` out `BLOCK_SIZE`: registered write data.
- `mem_rdata` in `BLOCK_SIZE`: downstream read data, valid when `mem_ready`=1.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If any `mX_valid` is high, pick a winner.
  - Latch the winner's addr, wdata and wstrb into the `mem_*` registers, store `grant` (0/1) and go to BUSY.
  - If no master is requesting, stay in IDLE.
- BUSY:
  - `mem_valid`=1 with stable `mem_*`.
  - On `mem_ready`=1, capture `mem_rdata` into `rdata_q`, clear `mem_valid` and go to DONE.
- DONE:
  - Assert `m[grant]_ready`=1 for exactly one cycle.
  - Go to IDLE. No new arbitration happens in this cycle.
- `m0_rdata` and `m1_rdata` are both driven from `rdata_q`. Each is meaningful only in the cycle its ready is high.
- Masters must hold valid and payload until their ready. If a master drops valid mid-transaction, the transaction still completes and the ready pulse is still issued.
- A write also returns a ready pulse. `rdata_q` is still loaded from `mem_rdata`, and its value is don't-care.
- Tie-break: see Configuration. A single requester always wins.
- `last_grant` updates in the IDLE->BUSY transition.

## Timing
- Reset values:
  - State IDLE.
  - `mem_valid`=0, `mem_wstrb`=0, `mem_addr`=0, `mem_wdata`=0.
  - `m0_ready`=`m1_ready`=0.
  - `rdata_q`=0, `grant`=0, `last_grant`=1.
- Latency: valid sampled in IDLE at edge N; `mem_valid`=1 from N+1. With `mem_ready` sampled at edge K, the master's ready is high in cycle K+1. The earliest next arbitration is at edge K+2.
- Minimum transaction is 3 cycles (`mem_ready` already high in the first BUSY cycle).
- `mem_valid` deasserts in the cycle after the `mem_ready` cycle. The downstream never sees a second valid&ready for the same request.
- `mem_ready` received in IDLE or DONE is ignored.
- Reset asserted mid-BUSY:
  - Next edge returns all state to reset values and `mem_valid` drops.
  - No ready pulse is issued.
  - The downstream transaction is abandoned.

## Configuration
Macro: `IOMEM_ARB_RR_EN`.
- Defined: round-robin tie-break. On simultaneous valid, grant the master not equal to `last_grant`. After reset the first tie goes to m0.
- Undefined: fixed priority, m1 always wins ties. `last_grant` is still maintained but unused.

## Structure
- Package `iomem_arb_pkg` holds:
  - State enum `arb_state_e` {IDLE, BUSY, DONE}.
  - `BLOCK_SIZE`, `NUMS_BYTE`, `ADDR_W` defaults.
  - Grant-index type.
- One sub-module, `iomem_arb_pick`: a combinational winner selection from (`m0_valid`, `m1_valid`, `last_grant`). It contains the `IOMEM_ARB_RR_EN` branch.
- The FSM and payload registers live in the top module.

## Test plan
- m0 alone reads 0x8000_0010, with `mem_ready` 16 cycles after `mem_valid` and `mem_rdata`=0xDEAD…BEEF. Expect `mem_addr`=0x8000_0010, `mem_wstrb`=0, one `m0_ready` pulse with `m0_rdata`=0xDEAD…BEEF, and `m1_ready` never high.
- m1 writes `wstrb`=0x000F, addr 0x8000_0020. Expect `mem_wstrb`=0x000F, `mem_wdata` equal to the input, and `mem_valid` low one cycle after `mem_ready`.
- Both valid simultaneously, held for 4 transactions.
  - With `IOMEM_ARB_RR_EN`: grant order m0, m1, m0, m1.
  - Without it: m1 is granted every time while it keeps requesting.
- `mem_ready` held high constantly. Expect 3-cycle transactions back to back, and no duplicate `mem_valid` between them.
- `rst_n` pulled low during BUSY. Expect `mem_valid`=0 and both readies 0 next cycle, state IDLE. A fresh m0 request after release completes normally.
